// File: rtl/l2_icache_resp.sv
// ---------------------------------------------------------------------------
// l2_icache_resp
//   L2-side responder for L1 icache refill requests. Accepts a request, looks
//   up a 2-way L2 (64 B lines) through synchronous-read tag/data arrays,
//   refills the line from memory on a miss (4 beats), writes it into the
//   victim way, and returns the addressed block to L1 with an l2_rdy pulse
//   followed by a complete/irq handshake. Read-only path, no writeback.
//
// Optional feature macro: L2_PERF_CNT_EN
//   defined   -> hit_cnt / miss_cnt count COMPARE hits / misses (wrap at 2^32)
//   undefined -> counters not built, hit_cnt / miss_cnt tied to 0
//
// Ports
//   clk_tmp, rst              clock, synchronous active-high reset
//   irq, l2_addr, l2_index    refill request from L1 (irq held until complete)
//   l2_cache_rw               request type, ignored (always serviced as read)
//   l2_busy, l2_rdy, complete handshake back to L1
//   l1_blk_wd                 block returned to L1
//   l2_arr_idx                L2 array address (latched index)
//   l2_tag{0,1}_rd            way tag reads {valid,tag}, 1-cycle latency
//   l2_data{0,1}_rd           way line reads
//   l2_lru                    victim select when both ways valid
//   l2_{tag,data}{0,1}_rw     one-cycle array write enables
//   l2_tag_wd, l2_data_wd     array write data
//   mem_req, mem_addr         memory line read request
//   mem_vld, mem_rd           memory beat return
//   hit_cnt, miss_cnt         performance counters
// ---------------------------------------------------------------------------
module l2_icache_resp #(
  parameter int L2_IDX_W = 9,
  parameter int L2_TAG_W = 17,
  parameter int L1_BLK_W = 128
) (
  input  logic                    clk_tmp,
  input  logic                    rst,
  input  logic                    irq,
  input  logic [31:0]             l2_addr,
  input  logic [L2_IDX_W-1:0]     l2_index,
  input  logic                    l2_cache_rw,
  output logic                    l2_busy,
  output logic                    l2_rdy,
  output logic                    complete,
  output logic [L1_BLK_W-1:0]     l1_blk_wd,
  output logic [L2_IDX_W-1:0]     l2_arr_idx,
  input  logic [L2_TAG_W:0]       l2_tag0_rd,
  input  logic [L2_TAG_W:0]       l2_tag1_rd,
  input  logic [4*L1_BLK_W-1:0]   l2_data0_rd,
  input  logic [4*L1_BLK_W-1:0]   l2_data1_rd,
  input  logic                    l2_lru,
  output logic                    l2_tag0_rw,
  output logic                    l2_tag1_rw,
  output logic                    l2_data0_rw,
  output logic                    l2_data1_rw,
  output logic [L2_TAG_W:0]       l2_tag_wd,
  output logic [4*L1_BLK_W-1:0]   l2_data_wd,
  output logic                    mem_req,
  output logic [31:0]             mem_addr,
  input  logic                    mem_vld,
  input  logic [L1_BLK_W-1:0]     mem_rd,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_COMPARE, S_MEM_FILL, S_L2_WRITE, S_DELIVER, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [31:0]             addr_q;
  logic [L2_IDX_W-1:0]     idx_q;
  logic [1:0]              beat_cnt_q;
  logic [4*L1_BLK_W-1:0]   line_q;
  logic [L1_BLK_W-1:0]     blk_q;
  logic                    victim_q;

  logic [L2_TAG_W-1:0]     req_tag;
  logic                    hit0, hit1, hit;
  logic [4*L1_BLK_W-1:0]   hit_line;
  logic [L1_BLK_W-1:0]     hit_blk, fill_blk;
  logic                    victim_sel;
  logic                    last_beat;

  assign req_tag   = addr_q[31 -: L2_TAG_W];
  assign hit0      = l2_tag0_rd[L2_TAG_W] && (l2_tag0_rd[L2_TAG_W-1:0] == req_tag);
  assign hit1      = l2_tag1_rd[L2_TAG_W] && (l2_tag1_rd[L2_TAG_W-1:0] == req_tag);
  assign hit       = hit0 | hit1;
  assign hit_line  = hit0 ? l2_data0_rd : l2_data1_rd;
  assign last_beat = mem_vld && (beat_cnt_q == 2'd3);

  // Invalid ways are filled first; LRU only arbitrates between two valid ways.
  assign victim_sel = !l2_tag0_rd[L2_TAG_W] ? 1'b0 :
                      !l2_tag1_rd[L2_TAG_W] ? 1'b1 : l2_lru;

  // Select the block addressed by addr_q[5:4] from the hit line and the fill buffer.
  always_comb begin
    hit_blk  = '0;
    fill_blk = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (addr_q[5:4] == k[1:0]) begin
        hit_blk  = hit_line[k*L1_BLK_W +: L1_BLK_W];
        fill_blk = line_q[k*L1_BLK_W +: L1_BLK_W];
      end
    end
  end

  // State register
  always_ff @(posedge clk_tmp) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (irq) state_d = S_LOOKUP;
      S_LOOKUP:   state_d = S_COMPARE;
      S_COMPARE:  state_d = hit ? S_DELIVER : S_MEM_FILL;
      S_MEM_FILL: if (last_beat) state_d = S_L2_WRITE;
      S_L2_WRITE: state_d = S_DELIVER;
      S_DELIVER:  state_d = S_DONE;
      S_DONE:     if (!irq) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Request latch, fill buffer and returned block
  always_ff @(posedge clk_tmp) begin
    if (rst) begin
      addr_q     <= '0;
      idx_q      <= '0;
      beat_cnt_q <= '0;
      line_q     <= '0;
      blk_q      <= '0;
      victim_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (irq) begin
            addr_q <= l2_addr;
            idx_q  <= l2_index;
          end
        end
        S_COMPARE: begin
          if (hit) blk_q <= hit_blk;
          else     beat_cnt_q <= '0;
        end
        S_MEM_FILL: begin
          if (mem_vld) begin
            for (int unsigned k = 0; k < 4; k++) begin
              if (beat_cnt_q == k[1:0]) line_q[k*L1_BLK_W +: L1_BLK_W] <= mem_rd;
            end
            beat_cnt_q <= beat_cnt_q + 2'd1;
            if (beat_cnt_q == 2'd3) victim_q <= victim_sel;
          end
        end
        S_L2_WRITE: blk_q <= fill_blk;
        default: ;
      endcase
    end
  end

  // Outputs decoded from state. Each registered set/clear pair of the original
  // handshake maps onto exactly one state, so decoding keeps identical timing.
  always_comb begin
    l2_busy     = (state_q != S_IDLE);
    l2_rdy      = (state_q == S_DELIVER);
    complete    = (state_q == S_DONE);
    mem_req     = (state_q == S_MEM_FILL);
    l2_tag0_rw  = 1'b0;
    l2_tag1_rw  = 1'b0;
    l2_data0_rw = 1'b0;
    l2_data1_rw = 1'b0;
    l2_tag_wd   = '0;
    if (state_q == S_L2_WRITE) begin
      l2_tag0_rw  = !victim_q;
      l2_data0_rw = !victim_q;
      l2_tag1_rw  = victim_q;
      l2_data1_rw = victim_q;
      l2_tag_wd   = {1'b1, req_tag};
    end
  end

  assign l1_blk_wd  = blk_q;
  assign l2_arr_idx = idx_q;
  assign l2_data_wd = line_q;
  assign mem_addr   = {addr_q[31:6], 6'b0};

`ifdef L2_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_tmp) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == S_COMPARE) begin
      if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else     miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

  // Request type and sub-block offset bits carry no meaning on this read-only path.
  logic unused_ok;
  assign unused_ok = ^{l2_cache_rw, addr_q[3:0]};

endmodule
